// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter sharing one 74158-style mux: drives Select/Enable_bar with
// break-before-make sequencing (disable, move Select, settle, re-enable).
module msa_delay_line #(
    parameter int           W   = 1,
    parameter int           D   = 1,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         Clk,
    input  logic         Clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [D-1:0][W-1:0] r_line;

    always_ff @(posedge Clk) begin
        if (Clear) begin
            for (int i = 0; i < D; i++) r_line[i] <= RST;
        end else begin
            r_line[0] <= i_d;
            for (int i = 1; i < D; i++) r_line[i] <= r_line[i-1];
        end
    end

    assign o_q = r_line[D-1];
endmodule

module mux_select_arbiter #(
    parameter int WIDTH_IN    = 2,
    parameter int DEAD_CYCLES = 2,
    parameter int MAX_HOLD    = 4,
    parameter int DELAY_RISE  = 0,
    parameter int DELAY_FALL  = 0
) (
    input  logic                        Clk,
    input  logic                        Clear,
    input  logic [WIDTH_IN-1:0]         Request,
    output logic [WIDTH_IN-1:0]         Grant,
    output logic [$clog2(WIDTH_IN)-1:0] Select,
    output logic                        Enable_bar,
    output logic                        Busy
);
    localparam int WIDTH_SELECT = $clog2(WIDTH_IN);
    localparam int CW           = $clog2(DEAD_CYCLES + 1);
    localparam int HW           = $clog2(MAX_HOLD + 2);
    localparam int HOLD_SAT     = (MAX_HOLD != 0) ? MAX_HOLD : (2**HW - 1);
    localparam int OW           = WIDTH_IN + WIDTH_SELECT + 2;
    localparam logic [OW-1:0] OUT_RST = OW'(1) << (WIDTH_IN + WIDTH_SELECT);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACTIVE, S_RELEASE} state_t;

    state_t                  r_state,  w_state_nxt;
    logic [WIDTH_SELECT-1:0] r_select, w_select_nxt;
    logic [WIDTH_SELECT-1:0] r_ptr,    w_ptr_nxt;
    logic [WIDTH_SELECT-1:0] r_winner, w_winner_nxt;
    logic [CW-1:0]           r_settle, w_settle_nxt;
    logic [HW-1:0]           r_hold,   w_hold_nxt;
    logic [WIDTH_IN-1:0]     r_grant,  w_grant_nxt;
    logic                    r_enb,    w_enb_nxt;
    logic                    r_busy,   w_busy_nxt;

    logic [WIDTH_IN-1:0]     w_req;
    logic [WIDTH_SELECT-1:0] w_pick;
    logic                    w_any;
    logic [WIDTH_IN-1:0]     w_win_onehot;
    logic                    w_win_req;
    logic                    w_others;
    logic                    w_hold_sat;
    logic                    w_hold_max;

    // Anything that is not a solid 1 (including X/Z) counts as no request.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < WIDTH_IN; i++) w_req[i] = (Request[i] === 1'b1);
    end

    // Scan downward so the offset closest to the pointer is written last and wins.
    always_comb begin
        w_pick = r_ptr;
        w_any  = 1'b0;
        for (int k = WIDTH_IN - 1; k >= 0; k--) begin
            int w_idx;
            w_idx = int'(r_ptr) + k;
            if (w_idx >= WIDTH_IN) w_idx = w_idx - WIDTH_IN;
            if (w_req[w_idx]) begin
                w_pick = WIDTH_SELECT'(w_idx);
                w_any  = 1'b1;
            end
        end
    end

    assign w_win_onehot = WIDTH_IN'(1) << r_winner;
    assign w_win_req    = |(w_req & w_win_onehot);
    assign w_others     = |(w_req & ~w_win_onehot);
    assign w_hold_sat   = (r_hold == HW'(HOLD_SAT));
    assign w_hold_max   = (MAX_HOLD != 0) && w_hold_sat;

    always_comb begin
        w_state_nxt  = r_state;
        w_select_nxt = r_select;
        w_ptr_nxt    = r_ptr;
        w_winner_nxt = r_winner;
        w_settle_nxt = r_settle;
        w_hold_nxt   = r_hold;
        w_grant_nxt  = r_grant;
        w_enb_nxt    = r_enb;
        w_busy_nxt   = r_busy;
        case (r_state)
            S_IDLE, S_RELEASE: begin
                if (w_any) begin
                    w_busy_nxt   = 1'b1;
                    w_winner_nxt = w_pick;
                    if (w_pick == r_select) begin
                        w_state_nxt = S_ACTIVE;
                        w_enb_nxt   = 1'b0;
                        w_grant_nxt = WIDTH_IN'(1) << w_pick;
                        w_hold_nxt  = HW'(1);
                    end else begin
                        // Mux is already disabled here, so Select may move now.
                        w_state_nxt  = S_SETTLE;
                        w_select_nxt = w_pick;
                        w_settle_nxt = CW'(DEAD_CYCLES);
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_enb_nxt   = 1'b1;
                    w_grant_nxt = '0;
                end
            end
            S_SETTLE: begin
                if (r_settle <= CW'(1)) begin
                    w_state_nxt = S_ACTIVE;
                    w_enb_nxt   = 1'b0;
                    w_grant_nxt = w_win_onehot;
                    w_hold_nxt  = HW'(1);
                end else begin
                    w_settle_nxt = r_settle - CW'(1);
                end
            end
            S_ACTIVE: begin
                if (!w_win_req || (w_hold_max && w_others)) begin
                    w_state_nxt = S_RELEASE;
                    w_enb_nxt   = 1'b1;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = (r_winner == WIDTH_SELECT'(WIDTH_IN - 1)) ?
                                  '0 : r_winner + WIDTH_SELECT'(1);
                end else if (!w_hold_sat) begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_enb_nxt   = 1'b1;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            r_state  <= S_IDLE;
            r_select <= '0;
            r_ptr    <= '0;
            r_winner <= '0;
            r_settle <= '0;
            r_hold   <= '0;
            r_grant  <= '0;
            r_enb    <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_select <= w_select_nxt;
            r_ptr    <= w_ptr_nxt;
            r_winner <= w_winner_nxt;
            r_settle <= w_settle_nxt;
            r_hold   <= w_hold_nxt;
            r_grant  <= w_grant_nxt;
            r_enb    <= w_enb_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Output edge delays are counted in Clk cycles; AND/OR of the two delayed
    // copies gives the longer delay on one edge and the shorter on the other.
    logic [OW-1:0] w_out_raw, w_rise_d, w_fall_d, w_out;
    assign w_out_raw = {r_busy, r_enb, r_select, r_grant};

    if (DELAY_RISE == 0) begin : g_rise_none
        assign w_rise_d = w_out_raw;
    end else begin : g_rise
        msa_delay_line #(.W(OW), .D(DELAY_RISE), .RST(OUT_RST)) u_line (
            .Clk(Clk), .Clear(Clear), .i_d(w_out_raw), .o_q(w_rise_d)
        );
    end

    if (DELAY_FALL == 0) begin : g_fall_none
        assign w_fall_d = w_out_raw;
    end else begin : g_fall
        msa_delay_line #(.W(OW), .D(DELAY_FALL), .RST(OUT_RST)) u_line (
            .Clk(Clk), .Clear(Clear), .i_d(w_out_raw), .o_q(w_fall_d)
        );
    end

    assign w_out = (DELAY_RISE >= DELAY_FALL) ? (w_rise_d & w_fall_d) : (w_rise_d | w_fall_d);
    assign {Busy, Enable_bar, Select, Grant} = w_out;
endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench for mux_select_arbiter: a cycle-level reference model predicts
// every output vector; a monitor compares and also checks the mux-safety invariants.
module tb_mux_select_arbiter;
    localparam int N    = 2;
    localparam int SW   = 1;
    localparam int DEAD = 2;
    localparam int MAXH = 4;

    logic          Clk = 1'b0;
    logic          Clear = 1'b1;
    logic [N-1:0]  Request = '0;
    logic [N-1:0]  Grant;
    logic [SW-1:0] Select;
    logic          Enable_bar;
    logic          Busy;

    mux_select_arbiter #(
        .WIDTH_IN(N), .DEAD_CYCLES(DEAD), .MAX_HOLD(MAXH), .DELAY_RISE(0), .DELAY_FALL(0)
    ) dut (
        .Clk(Clk), .Clear(Clear), .Request(Request), .Grant(Grant),
        .Select(Select), .Enable_bar(Enable_bar), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [N-1:0]  grant;
        logic [SW-1:0] sel;
        logic          enb;
        logic          busy;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: what the mux "is doing" right now.
    typedef enum {M_IDLE, M_WAIT, M_OWNED, M_GAP} phase_t;
    phase_t m_phase = M_IDLE;
    int     m_sel = 0, m_ptr = 0, m_owner = 0, m_wait = 0, m_held = 0;

    function automatic int pick(input logic [N-1:0] req);
        for (int k = 0; k < N; k++)
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_step(input logic clr, input logic [N-1:0] req);
        exp_t e;
        int   w;
        int   others;
        if (clr) begin
            m_phase = M_IDLE; m_sel = 0; m_ptr = 0; m_owner = 0; m_wait = 0; m_held = 0;
        end else begin
            case (m_phase)
                M_IDLE, M_GAP: begin
                    w = pick(req);
                    if (w < 0) m_phase = M_IDLE;
                    else begin
                        m_owner = w;
                        if (w == m_sel) begin m_phase = M_OWNED; m_held = 1; end
                        else begin m_sel = w; m_wait = DEAD; m_phase = M_WAIT; end
                    end
                end
                M_WAIT: begin
                    if (m_wait == 1) begin m_phase = M_OWNED; m_held = 1; end
                    else m_wait--;
                end
                M_OWNED: begin
                    others = 0;
                    for (int i = 0; i < N; i++) if (i != m_owner && req[i]) others = 1;
                    if (!req[m_owner] || (MAXH != 0 && m_held >= MAXH && others != 0)) begin
                        m_phase = M_GAP;
                        m_ptr = (m_owner + 1) % N;
                    end else m_held++;
                end
                default: m_phase = M_IDLE;
            endcase
        end
        e.sel   = SW'(m_sel);
        e.enb   = (m_phase != M_OWNED);
        e.grant = (m_phase == M_OWNED) ? N'(1) << m_owner : '0;
        e.busy  = (m_phase != M_IDLE);
        sb_q.push_back(e);
    endtask

    task automatic cycle(input logic clr, input logic [N-1:0] req);
        @(negedge Clk);
        Clear   = clr;
        Request = req;
        model_step(clr, req);
    endtask

    // Monitor: one expected vector per edge, plus invariants between edges.
    initial begin
        exp_t          e;
        logic          clr_edge;
        logic          started = 1'b0;
        logic [SW-1:0] prev_sel = '0;
        logic          prev_enb = 1'b1;
        forever begin
            @(posedge Clk);
            clr_edge = Clear;
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (Grant !== e.grant || Select !== e.sel || Enable_bar !== e.enb || Busy !== e.busy) begin
                    bad++;
                    $display("FAIL outputs t=%0t got grant=%b sel=%0d enb=%b busy=%b want grant=%b sel=%0d enb=%b busy=%b",
                             $time, Grant, Select, Enable_bar, Busy, e.grant, e.sel, e.enb, e.busy);
                end
                if (started && !Enable_bar) begin
                    total++;
                    if (!$onehot(Grant) || !Grant[Select]) begin
                        bad++;
                        $display("FAIL grant_onehot t=%0t got grant=%b sel=%0d want one-hot with Grant[Select]=1",
                                 $time, Grant, Select);
                    end
                end
                if (started && !clr_edge && Select != prev_sel) begin
                    total++;
                    if (!prev_enb || !Enable_bar) begin
                        bad++;
                        $display("FAIL break_before_make t=%0t got enb prev=%b now=%b on sel change want 1/1",
                                 $time, prev_enb, Enable_bar);
                    end
                end
                started  = 1'b1;
                prev_sel = Select;
                prev_enb = Enable_bar;
            end
        end
    end

    initial begin
        int len;
        logic [N-1:0] r;
        // reset, then request 0 with no settle, voluntary release, idle
        cycle(1'b1, 2'b00);
        cycle(1'b0, 2'b01);
        repeat (3) cycle(1'b0, 2'b01);
        repeat (3) cycle(1'b0, 2'b00);
        // reset, then request 1 needing settle
        cycle(1'b1, 2'b00);
        repeat (6) cycle(1'b0, 2'b10);
        repeat (2) cycle(1'b0, 2'b00);
        // reset mid-SETTLE toward requester 1
        cycle(1'b1, 2'b00);
        repeat (2) cycle(1'b0, 2'b10);
        cycle(1'b1, 2'b10);
        repeat (6) cycle(1'b0, 2'b10);
        // fair rotation with both held, then reset from ACTIVE
        cycle(1'b1, 2'b00);
        repeat (30) cycle(1'b0, 2'b11);
        cycle(1'b1, 2'b11);
        repeat (5) cycle(1'b0, 2'b11);
        // winner drops during SETTLE
        cycle(1'b1, 2'b00);
        cycle(1'b0, 2'b10);
        cycle(1'b0, 2'b01);
        repeat (6) cycle(1'b0, 2'b01);
        // random held request patterns with occasional reset
        repeat (250) begin
            r   = N'($urandom_range(0, 3));
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 39) == 0) cycle(1'b1, r);
            repeat (len) cycle(1'b0, r);
        end
        repeat (4) cycle(1'b0, 2'b00);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge Clk);
            #2;
        end
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
